// File: rtl/fdc_sector_server.sv
// Sector server between the nec765 FDC core and the memory arbiter.
// Moves 512-byte sectors between two byte-wide disk images and the FDC FIFOs.
module fdc_sector_server #(
    parameter int          ADDR_W   = 24,
    parameter int unsigned TRACKS   = 40,
    parameter int unsigned SIDES    = 1,
    parameter int unsigned SECTORS  = 9,
    parameter logic [7:0]  FIRST_ID = 8'hC1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       disk_sr,
    output logic [31:0]       disk_cr,
    output logic [7:0]        disk_data_in,
    output logic              disk_data_clkin,
    input  logic [7:0]        disk_data_out,
    output logic              disk_data_clkout,
    input  logic [1:0]        img_mounted,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD_MEM, S_RD_PUSH, S_WR_POP, S_WR_MEM, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_sr;
    logic              r_req_d;
    logic              r_wr, r_drv, r_head, r_err, r_mnt_a;
    logic [6:0]        r_cyl;
    logic [7:0]        r_id, r_rdata, r_wdata;
    logic [8:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;

    logic              w_req, w_start, w_bad, w_last;
    logic [31:0]       w_lba;
    logic [ADDR_W-1:0] w_base;
    logic              w_unused;

    assign w_req   = r_sr[21] | r_sr[20] | r_sr[18] | r_sr[17];
    assign w_start = (r_state == S_IDLE) && w_req && !r_req_d;
    assign w_last  = &r_cnt;
    assign w_base  = r_drv ? base_b : base_a;
    assign w_lba   = (32'(r_cyl) * SIDES + 32'(r_head)) * SECTORS
                   + 32'(r_id) - 32'(FIRST_ID);
    assign w_bad   = !img_mounted[r_drv] || (32'(r_cyl) >= TRACKS)
                   || (32'(r_head) >= SIDES) || (r_id < FIRST_ID)
                   || (32'(r_id) >= 32'(FIRST_ID) + SECTORS);
    assign w_unused = &{1'b0, r_sr[31:22], r_sr[19], r_sr[16], w_lba[31:23]};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        mem_rd           = 1'b0;
        mem_wr           = 1'b0;
        disk_data_clkin  = 1'b0;
        disk_data_clkout = 1'b0;
        case (r_state)
            S_IDLE:    if (w_start) w_next = S_CHECK;
            S_CHECK: begin
                if (!w_req)     w_next = S_IDLE;
                else if (w_bad) w_next = S_DONE;
                else            w_next = r_wr ? S_WR_POP : S_RD_MEM;
            end
            // an open memory handshake is always completed, even when aborting
            S_RD_MEM: begin
                mem_rd = 1'b1;
                if (mem_ready) w_next = w_req ? S_RD_PUSH : S_IDLE;
            end
            S_RD_PUSH: begin
                disk_data_clkin = w_req;
                if (!w_req)      w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
                else             w_next = S_RD_MEM;
            end
            S_WR_POP: begin
                disk_data_clkout = w_req;
                w_next = w_req ? S_WR_MEM : S_IDLE;
            end
            S_WR_MEM: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    if (!w_req)      w_next = S_IDLE;
                    else if (w_last) w_next = S_DONE;
                    else             w_next = S_WR_POP;
                end
            end
            S_DONE:    if (!w_req) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_req_d <= 1'b0;
            r_mnt_a <= 1'b0;
            r_wr    <= 1'b0;
            r_drv   <= 1'b0;
            r_head  <= 1'b0;
            r_cyl   <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_wdata <= '0;
        end else begin
            r_sr    <= disk_sr;
            r_req_d <= w_req;
            r_mnt_a <= img_mounted[0];
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_wr   <= !(r_sr[17] || r_sr[18]);
                    r_drv  <= r_sr[17] ? 1'b0 : r_sr[18] ? 1'b1 : !r_sr[20];
                    r_head <= r_sr[15];
                    r_cyl  <= r_sr[14:8];
                    r_id   <= r_sr[7:0];
                end
                S_CHECK: begin
                    r_err  <= w_bad;
                    r_cnt  <= '0;
                    r_addr <= w_base + ADDR_W'({w_lba[22:0], 9'b0});
                end
                S_RD_MEM:  if (mem_ready) r_rdata <= mem_rdata;
                S_RD_PUSH: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt + 9'd1;
                end
                S_WR_POP:  r_wdata <= disk_data_out;
                S_WR_MEM:  if (mem_ready) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt + 9'd1;
                end
                default: ;
            endcase
        end
    end

    assign disk_data_in = r_rdata;
    assign mem_wdata    = r_wdata;
    assign mem_addr     = r_addr;
    assign disk_cr      = {(r_mnt_a ? FIRST_ID : 8'h00), 19'b0,
                           r_state == S_DONE, (r_state == S_DONE) && r_err, 3'b0};

endmodule

// File: tb/tb_fdc_sector_server.sv
// Randomized bench: behavioural memory/FIFO model plus sector-address reference
// arithmetic; every transfer is checked byte by byte.
module tb_fdc_sector_server;
    localparam int         SECT = 9;
    localparam int         SIDS = 1;
    localparam logic [7:0] FID  = 8'hC1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] disk_sr, disk_cr;
    logic [7:0]  disk_data_in, disk_data_out;
    logic        disk_data_clkin, disk_data_clkout;
    logic [1:0]  img_mounted;
    logic [23:0] base_a, base_b, mem_addr;
    logic        mem_rd, mem_wr, mem_ready;
    logic [7:0]  mem_wdata, mem_rdata;

    fdc_sector_server dut (
        .clk(clk), .rst_n(rst_n), .disk_sr(disk_sr), .disk_cr(disk_cr),
        .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
        .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
        .img_mounted(img_mounted), .base_a(base_a), .base_b(base_b),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:(1<<19)-1];
    logic [7:0]  wbuf [512];
    logic [7:0]  rxq[$];
    logic [23:0] accq[$];
    int n_clkin = 0, n_clkout = 0, n_mem = 0, n_pop = 0;
    int wbase = 0, waits = 0;
    int n_tot = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lba(input int cyl, input int head, input int id);
        return (cyl * SIDS + head) * SECT + id - int'(FID);
    endfunction

    // memory arbiter with programmable wait states, and the FDC FIFOs
    initial begin
        int wcnt;
        bit pop_pend;
        wcnt = 0; pop_pend = 0;
        mem_ready = 1'b0; mem_rdata = '0; disk_data_out = '0;
        for (int i = 0; i < (1<<19); i++) mem[i] = 8'($urandom);
        forever begin
            @(negedge clk);
            if (pop_pend) begin n_pop++; pop_pend = 0; end
            disk_data_out = wbuf[(n_pop - wbase) % 512];
            if (disk_data_clkin)  begin rxq.push_back(disk_data_in); n_clkin++; end
            if (disk_data_clkout) begin pop_pend = 1; n_clkout++; end
            if (mem_rd || mem_wr) n_mem++;
            if (mem_ready) begin
                mem_ready = 1'b0; wcnt = 0;
            end else if (mem_rd || mem_wr) begin
                if (wcnt >= waits) begin
                    mem_ready = 1'b1;
                    accq.push_back(mem_addr);
                    if (mem_rd) mem_rdata = mem[mem_addr[18:0]];
                    else        mem[mem_addr[18:0]] = mem_wdata;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic run_req(input logic [31:0] sr, input int budget, output int cyc);
        disk_sr = sr;
        cyc = 0;
        while (!disk_cr[4] && cyc < budget) begin step(1); cyc++; end
        chk("req_done", disk_cr[4], 1'b1);
    endtask

    task automatic drop_req();
        disk_sr = '0;
        step(2);
        chk("done_clr", disk_cr[4:3], 2'b00);
    endtask

    task automatic verify_read(input int rb, input int ab, input int ea, input string tag);
        int mism;
        mism = 0;
        chk({tag, "_cnt"}, rxq.size() - rb, 512);
        if (rxq.size() - rb >= 512 && accq.size() - ab >= 512) begin
            for (int i = 0; i < 512; i++) begin
                if (rxq[rb+i] !== mem[ea+i]) mism++;
                if (int'(accq[ab+i]) != ea + i) mism++;
            end
        end else mism = 999;
        chk({tag, "_data"}, mism, 0);
        chk({tag, "_err"}, disk_cr[3], 1'b0);
    endtask

    initial begin
        int cyc, rb, ab, ci, cm, co, ea, mism, c, id, drv;
        bit held, nd;
        logic [31:0] sr;
        logic [31:0] esr [4];
        logic [1:0]  emnt [4];

        rst_n = 1'b0; disk_sr = '0; img_mounted = 2'b00;
        base_a = 24'h001000; base_b = 24'h040000;
        step(3);
        chk("rst_cr", disk_cr, 32'h0);
        chk("rst_strobes", {mem_rd, mem_wr, disk_data_clkin, disk_data_clkout}, 4'h0);
        chk("rst_addr", mem_addr, 24'h0);
        chk("rst_din", disk_data_in, 8'h0);
        rst_n = 1'b1; img_mounted = 2'b11;
        step(2);
        chk("cr_first_id", disk_cr[31:24], FID);

        // read A, cyl 2 head 0 ID C3, zero-wait
        rb = rxq.size(); ab = accq.size(); waits = 0;
        run_req(32'h0002_0000 | (32'd2 << 8) | 32'hC3, 5000, cyc);
        chk("rd_a_addr0", (accq.size() > ab) ? accq[ab] : 24'hFFFFFF, 24'h003800);
        verify_read(rb, ab, 32'h3800, "rd_a");
        chk("rd_a_rate", cyc >= 1024, 1'b1);
        held = 1;
        repeat (10) begin step(1); held &= disk_cr[4]; end
        chk("done_hold", held, 1'b1);
        drop_req();

        // rejected requests: ID below/above range, cyl 40, unmounted drive B
        esr[0] = 32'h0002_0000 | (32'd2 << 8) | 32'hC0;  emnt[0] = 2'b11;
        esr[1] = 32'h0002_0000 | 32'hCA;                 emnt[1] = 2'b11;
        esr[2] = 32'h0002_0000 | (32'd40 << 8) | 32'hC1; emnt[2] = 2'b11;
        esr[3] = 32'h0004_0000 | 32'hC1;                 emnt[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            img_mounted = emnt[k];
            step(1);
            ci = n_clkin; cm = n_mem;
            run_req(esr[k], 20, cyc);
            chk($sformatf("err%0d_flag", k), disk_cr[3], 1'b1);
            chk($sformatf("err%0d_lat", k), cyc <= 3, 1'b1);
            chk($sformatf("err%0d_traffic", k), (n_clkin - ci) + (n_mem - cm), 0);
            drop_req();
        end
        img_mounted = 2'b11;

        // write B with 3 stall cycles per access
        c = $urandom_range(0, 39); id = int'(FID) + $urandom_range(0, 8);
        ea = int'(base_b) + lba(c, 0, id) * 512;
        for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
        wbase = n_pop; waits = 3; co = n_clkout; ab = accq.size();
        run_req(32'h0020_0000 | (32'(c) << 8) | 32'(id), 10000, cyc);
        chk("wr_b_pulses", n_clkout - co, 512);
        mism = 0;
        if (accq.size() - ab >= 512) begin
            for (int i = 0; i < 512; i++) begin
                if (mem[ea+i] !== wbuf[i]) mism++;
                if (int'(accq[ab+i]) != ea + i) mism++;
            end
        end else mism = 999;
        chk("wr_b_data", mism, 0);
        chk("wr_b_err", disk_cr[3], 1'b0);
        drop_req();
        waits = 0;

        // abort a read after 100 bytes
        ci = n_clkin;
        disk_sr = 32'h0002_0000 | (32'd5 << 8) | 32'hC5;
        cyc = 0;
        while (n_clkin - ci < 100 && cyc < 2000) begin step(1); cyc++; end
        disk_sr = '0;
        nd = 0;
        repeat (20) begin step(1); nd |= disk_cr[4]; end
        chk("ab_count", n_clkin - ci, 100);
        chk("ab_nodone", nd, 1'b0);
        chk("ab_idle", {mem_rd, mem_wr}, 2'b00);

        // randomized reads, first one right after the abort
        for (int k = 0; k < 4; k++) begin
            drv = $urandom_range(0, 1); waits = $urandom_range(0, 2);
            c = $urandom_range(0, 39); id = int'(FID) + $urandom_range(0, 8);
            ea = (drv ? int'(base_b) : int'(base_a)) + lba(c, 0, id) * 512;
            sr = (drv ? 32'h0004_0000 : 32'h0002_0000) | (32'(c) << 8) | 32'(id);
            rb = rxq.size(); ab = accq.size();
            run_req(sr, 5000, cyc);
            verify_read(rb, ab, ea, $sformatf("rnd%0d", k));
            drop_req();
        end
        waits = 0;

        // reset in the middle of a write handshake
        img_mounted = 2'b10;
        step(2);
        waits = 3;
        disk_sr = 32'h0020_0000 | 32'hC1;
        cyc = 0;
        while (!mem_wr && cyc < 100) begin step(1); cyc++; end
        chk("rs_mem_wr", mem_wr, 1'b1);
        rst_n = 1'b0;
        step(1);
        chk("rs_strobes", {mem_rd, mem_wr, disk_data_clkin, disk_data_clkout}, 4'h0);
        chk("rs_cr", disk_cr, 32'h0);
        chk("rs_addr", mem_addr, 24'h0);
        disk_sr = '0; rst_n = 1'b1; waits = 0;
        step(3);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
